// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between the fetch (IF) and
// memory-access (D) stages; alternates grants under contention and drives stalls.
module mem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  state_t     state, state_nx;
  port_t      sel, last;
  logic [2:0] cnt;
  logic       wr;
  logic       elig_if, elig_d, grant, gnt_d, done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = BUSY;
      BUSY:    if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A port whose ack is high this cycle is about to drop its request, so it is
  // masked out of arbitration to avoid a spurious re-grant.
  always_comb begin
    elig_if  = if_req & ~if_ack;
    elig_d   = d_req & ~d_ack;
    grant    = (state == IDLE) & (elig_if | elig_d);
    gnt_d    = elig_d & (~elig_if | (last == PORT_IF));
    done     = (state == BUSY) & (cnt == '0);
    if_stall = if_req & ~if_ack;
    d_stall  = d_req & ~d_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel      <= PORT_IF;
      last     <= PORT_IF;
      cnt      <= '0;
      wr       <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      m_en   <= 1'b0;
      m_we   <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant) begin
        sel     <= gnt_d ? PORT_D : PORT_IF;
        last    <= gnt_d ? PORT_D : PORT_IF;
        wr      <= gnt_d & d_we;
        m_en    <= 1'b1;
        m_we    <= gnt_d & d_we;
        m_addr  <= gnt_d ? d_addr : if_addr;
        m_wdata <= d_wdata;
        cnt     <= 3'(LAT);
      end else if (state == BUSY) begin
        if (cnt != '0) cnt <= cnt - 3'd1;
        if (done) begin
          if (sel == PORT_D) begin
            d_ack <= 1'b1;
            if (!wr) d_rdata <= m_rdata;
          end else begin
            if_ack <= 1'b1;
            if (!wr) if_rdata <= m_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/acks queued at stimulus time,
// popped and compared by a negedge monitor; scenario tasks add direct checks.
module tb_mem_arbiter;

  typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } gnt_t;
  typedef struct { int cyc; logic [31:0] data; } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, sw_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, if_stall, d_ack, d_stall, m_en, m_we;
  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1, if_rdata7, d_rdata7, m_addr7, m_wdata7;
  logic        if_ack1, if_stall1, d_ack1, d_stall1, m_en1, m_we1;
  logic        if_ack7, if_stall7, d_ack7, d_stall7, m_en7, m_we7;

  int n_checks = 0, n_fail = 0, cyc = 0, n_ack_seen = 0;
  gnt_t exp_g[$];
  ack_t exp_ia[$], exp_da[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] maddr = '0, exp_drd = '0;
  int mcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_stall(if_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall), .m_en(m_en),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .if_req(sw_req), .if_addr(if_addr), .if_rdata(if_rdata1),
    .if_ack(if_ack1), .if_stall(if_stall1), .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0),
    .d_wdata(32'h0), .d_rdata(d_rdata1), .d_ack(d_ack1), .d_stall(d_stall1), .m_en(m_en1),
    .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata));

  mem_arbiter #(.AW(32), .DW(32), .LAT(7)) u_dut7 (
    .clk(clk), .rst(rst), .if_req(sw_req), .if_addr(if_addr), .if_rdata(if_rdata7),
    .if_ack(if_ack7), .if_stall(if_stall7), .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0),
    .d_wdata(32'h0), .d_rdata(d_rdata7), .d_ack(d_ack7), .d_stall(d_stall7), .m_en(m_en7),
    .m_we(m_we7), .m_addr(m_addr7), .m_wdata(m_wdata7), .m_rdata(m_rdata));

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic gnt_t mk_g(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
    gnt_t g;
    g.cyc = c; g.addr = a; g.we = we; g.wdata = wd;
    return g;
  endfunction

  function automatic ack_t mk_a(input int c, input logic [31:0] d);
    ack_t a;
    a.cyc = c; a.data = d;
    return a;
  endfunction

  // Memory model for the LAT=2 instance: samples while m_en is high, presents
  // data only in the cycle before the capture edge, garbage otherwise.
  always @(negedge clk) begin
    m_rdata = 32'hDEAD_BEEF;
    if (m_en) begin
      maddr = m_addr;
      if (m_we) mem[m_addr] = m_wdata;
      mcnt = 2;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) m_rdata = rd(maddr);
    end
  end

  gnt_t mg;
  ack_t ma;
  always @(negedge clk) begin
    if (rst) begin
      if (m_en) begin
        n_checks++;
        if (exp_g.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got addr=%h we=%b at cycle %0d, required no grant", m_addr, m_we, cyc);
        end else begin
          mg = exp_g.pop_front();
          if (cyc !== mg.cyc || m_addr !== mg.addr || m_we !== mg.we || (mg.we && m_wdata !== mg.wdata)) begin
            n_fail++;
            $display("FAIL grant: got cyc=%0d addr=%h we=%b wdata=%h, required cyc=%0d addr=%h we=%b wdata=%h",
                     cyc, m_addr, m_we, m_wdata, mg.cyc, mg.addr, mg.we, mg.wdata);
          end
        end
      end
      if (if_ack) begin
        n_ack_seen++;
        n_checks++;
        if (exp_ia.size() == 0) begin
          n_fail++;
          $display("FAIL if_ack_unexpected: got ack at cycle %0d, required none", cyc);
        end else begin
          ma = exp_ia.pop_front();
          if (cyc !== ma.cyc || if_rdata !== ma.data) begin
            n_fail++;
            $display("FAIL if_ack: got cyc=%0d rdata=%h, required cyc=%0d rdata=%h", cyc, if_rdata, ma.cyc, ma.data);
          end
        end
      end
      if (d_ack) begin
        n_ack_seen++;
        n_checks++;
        if (exp_da.size() == 0) begin
          n_fail++;
          $display("FAIL d_ack_unexpected: got ack at cycle %0d, required none", cyc);
        end else begin
          ma = exp_da.pop_front();
          if (cyc !== ma.cyc || d_rdata !== ma.data) begin
            n_fail++;
            $display("FAIL d_ack: got cyc=%0d rdata=%h, required cyc=%0d rdata=%h", cyc, d_rdata, ma.cyc, ma.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({m_en, m_we, if_ack, d_ack, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b we=%b acks=%b%b addr=%h wdata=%h, required all zero",
               m_en, m_we, if_ack, d_ack, m_addr, m_wdata);
    end
    if_req = 1'b1; d_req = 1'b1; #1;
    n_checks++;
    if ({if_stall, d_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_stall: got %b, required 11", {if_stall, d_stall});
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(2);
    n_checks++;
    if ({m_en, if_ack, d_ack, m_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got en=%b addr=%h, required zero", m_en, m_addr);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_single_read;
    int c;
    bit got = 0;
    c = cyc;
    exp_g.push_back(mk_g(c + 1, 32'h10, 1'b0, 32'h0));
    exp_ia.push_back(mk_a(c + 4, 32'hAAAA5555));
    if_addr = 32'h10; if_req = 1'b1;
    tick(1);
    n_checks++;
    if (if_stall !== 1'b1) begin n_fail++; $display("FAIL read_stall_wait: got %b, required 1", if_stall); end
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_ack) got = 1; else tick(1);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL read_ack_timeout: got no if_ack, required one"); end
    else if (if_stall !== 1'b0) begin n_fail++; $display("FAIL read_stall_ack: got %b, required 0", if_stall); end
    if_req = 1'b0;
    tick(3);
    n_checks++;
    if (exp_g.size() + exp_ia.size() != 0) begin n_fail++; $display("FAIL read_pending: got %0d outstanding, required 0", exp_g.size() + exp_ia.size()); end
    n_checks++;
    if (if_rdata !== 32'hAAAA5555) begin n_fail++; $display("FAIL read_hold: got %h, required aaaa5555", if_rdata); end
  endtask

  task automatic test_contention;
    int c;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    c = cyc;
    if_addr = 32'h14; d_addr = 32'h20; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    exp_g.push_back(mk_g(c + 1,  32'h20, 1'b0, 32'h0));
    exp_g.push_back(mk_g(c + 5,  32'h14, 1'b0, 32'h0));
    exp_g.push_back(mk_g(c + 9,  32'h20, 1'b0, 32'h0));
    exp_g.push_back(mk_g(c + 13, 32'h14, 1'b0, 32'h0));
    exp_da.push_back(mk_a(c + 4,  rd(32'h20)));
    exp_da.push_back(mk_a(c + 12, rd(32'h20)));
    exp_ia.push_back(mk_a(c + 8,  rd(32'h14)));
    exp_ia.push_back(mk_a(c + 16, rd(32'h14)));
    exp_drd = rd(32'h20);
    tick(3);
    n_checks++;
    if ({if_stall, d_stall} !== 2'b11) begin n_fail++; $display("FAIL contend_stall: got %b, required 11", {if_stall, d_stall}); end
    while (cyc < c + 13) tick(1);
    if_req = 1'b0; d_req = 1'b0;
    tick(6);
    n_checks++;
    if (exp_g.size() + exp_ia.size() + exp_da.size() != 0) begin
      n_fail++;
      $display("FAIL contend_pending: got %0d outstanding, required 0", exp_g.size() + exp_ia.size() + exp_da.size());
    end
  endtask

  task automatic test_write;
    int c;
    bit got;
    c = cyc;
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; d_req = 1'b1;
    exp_g.push_back(mk_g(c + 1, 32'h40, 1'b1, 32'h1234));
    exp_da.push_back(mk_a(c + 4, exp_drd));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (d_ack) got = 1; else tick(1);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick(3);
    c = cyc;
    d_req = 1'b1;
    exp_g.push_back(mk_g(c + 1, 32'h40, 1'b0, 32'h0));
    exp_da.push_back(mk_a(c + 4, 32'h1234));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (d_ack) got = 1; else tick(1);
    end
    d_req = 1'b0;
    tick(3);
    n_checks++;
    if (exp_g.size() + exp_da.size() != 0) begin
      n_fail++;
      $display("FAIL write_pending: got %0d outstanding, required 0", exp_g.size() + exp_da.size());
    end
  endtask

  task automatic test_hold_through_ack;
    int c;
    c = cyc;
    if_addr = 32'h18; if_req = 1'b1;
    exp_g.push_back(mk_g(c + 1, 32'h18, 1'b0, 32'h0));
    exp_ia.push_back(mk_a(c + 4, rd(32'h18)));
    exp_g.push_back(mk_g(c + 6, 32'h18, 1'b0, 32'h0));
    exp_ia.push_back(mk_a(c + 9, rd(32'h18)));
    while (cyc < c + 6) tick(1);
    if_req = 1'b0;
    tick(6);
    n_checks++;
    if (exp_g.size() + exp_ia.size() != 0) begin
      n_fail++;
      $display("FAIL hold_pending: got %0d outstanding, required 0", exp_g.size() + exp_ia.size());
    end
  endtask

  task automatic test_reset_mid;
    int c, acks_before;
    bit got;
    c = cyc;
    if_addr = 32'h30; if_req = 1'b1;
    exp_g.push_back(mk_g(c + 1, 32'h30, 1'b0, 32'h0));
    while (cyc < c + 2) tick(1);
    rst = 1'b0; if_req = 1'b0;
    #1;
    n_checks++;
    if ({m_en, m_we, if_ack, d_ack, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got addr=%h if_rdata=%h d_rdata=%h, required zero", m_addr, if_rdata, d_rdata);
    end
    acks_before = n_ack_seen;
    tick(1);
    rst = 1'b1;
    tick(8);
    n_checks++;
    if (n_ack_seen != acks_before || exp_g.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_noack: got %0d acks %0d grants pending, required 0 and 0", n_ack_seen - acks_before, exp_g.size());
    end
    c = cyc;
    if_req = 1'b1;
    exp_g.push_back(mk_g(c + 1, 32'h30, 1'b0, 32'h0));
    exp_ia.push_back(mk_a(c + 4, rd(32'h30)));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_ack) got = 1; else tick(1);
    end
    if_req = 1'b0;
    tick(3);
    n_checks++;
    if (exp_g.size() + exp_ia.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_resume: got %0d outstanding, required 0", exp_g.size() + exp_ia.size());
    end
  endtask

  task automatic test_lat_sweep;
    int c, g1 = -1, a1 = -1, g7 = -1, a7 = -1;
    tick(2);
    c = cyc;
    if_addr = 32'h50; sw_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (g1 < 0 && m_en1) g1 = cyc;
      if (a1 < 0 && if_ack1) a1 = cyc;
      if (g7 < 0 && m_en7) g7 = cyc;
      if (a7 < 0 && if_ack7) begin a7 = cyc; sw_req = 1'b0; end
    end
    n_checks++;
    if (g1 != c + 1 || a1 - g1 != 2) begin n_fail++; $display("FAIL lat1: got grant=%0d latency=%0d, required grant=%0d latency=2", g1, a1 - g1, c + 1); end
    n_checks++;
    if (g7 != c + 1 || a7 - g7 != 8) begin n_fail++; $display("FAIL lat7: got grant=%0d latency=%0d, required grant=%0d latency=8", g7, a7 - g7, c + 1); end
    n_checks++;
    if ({d_ack1, d_ack7, m_we1, m_we7, d_stall1, d_stall7, m_addr7 != 32'h50} !== '0) begin
      n_fail++;
      $display("FAIL sweep_idle_d: got m_addr7=%h d_ack=%b%b, required 00000050 and 00", m_addr7, d_ack1, d_ack7);
    end
  endtask

  initial begin
    mem[32'h10] = 32'hAAAA5555;
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_hold_through_ack();
    test_reset_mid();
    test_lat_sweep();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
